// File: rtl/cpu_pkg.sv
// Shared types for the data-memory path: requester identity and default widths.
package cpu_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int WAIT_W     = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

endpackage

// File: rtl/dmem_rsp_router.sv
// Tags each issued read with its owner and steers the next-cycle memory data
// to that owner, holding the last response on each port between reads.
module dmem_rsp_router
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  owner_t            rd_tag_d,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid
);

  owner_t            rd_tag;
  logic [DATA_W-1:0] cpu_hold;
  logic [DATA_W-1:0] dbg_hold;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_tag   <= OWN_NONE;
      cpu_hold <= '0;
      dbg_hold <= '0;
    end else begin
      rd_tag <= rd_tag_d;
      if (rd_tag == OWN_CPU) cpu_hold <= mem_rdata;
      if (rd_tag == OWN_DBG) dbg_hold <= mem_rdata;
    end
  end

  // Response is presented straight from the memory in the cycle after issue;
  // the hold register only supplies the value once rvalid has dropped.
  assign cpu_rvalid = (rd_tag == OWN_CPU);
  assign dbg_rvalid = (rd_tag == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_hold;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_hold;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU has priority, the debug port is forced
// through after MAX_WAIT consecutive denials.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_SAT   = '1;

  logic [WAIT_W-1:0] wait_cnt;
  logic              force_dbg;
  owner_t            winner;
  owner_t            rd_tag_d;

  assign force_dbg = dbg_req && (wait_cnt >= MAX_WAIT_C);

  always_comb begin
    winner    = OWN_NONE;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (force_dbg)    winner = OWN_DBG;
    else if (cpu_req) winner = OWN_CPU;
    else if (dbg_req) winner = OWN_DBG;
    case (winner)
      OWN_CPU: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      OWN_DBG: begin
        mem_we    = dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
      end
      default: ;
    endcase
  end

  assign cpu_stall = cpu_req && (winner != OWN_CPU);
  assign dbg_gnt   = (winner == OWN_DBG);
  assign rd_tag_d  = (winner != OWN_NONE && !mem_we) ? winner : OWN_NONE;

  // Counts consecutive denied debug cycles; any grant or idle cycle restarts it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                   wait_cnt <= '0;
    else if (!dbg_req || dbg_gnt) wait_cnt <= '0;
    else if (wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + 1'b1;
  end

  dmem_rsp_router #(.DATA_W(DATA_W)) u_rsp (
    .clk        (clk),
    .rstn       (rstn),
    .rd_tag_d   (rd_tag_d),
    .mem_rdata  (mem_rdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .dbg_rdata  (dbg_rdata),
    .dbg_rvalid (dbg_rvalid)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model of arbitration, memory and responses.
module tb_dmem_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;
  localparam int W_NONE = 0, W_CPU = 1, W_DBG = 2;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_stall, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dbg_req = 1'b0, dbg_we = 1'b0;
  logic [ADDR_W-1:0] dbg_addr = '0;
  logic [DATA_W-1:0] dbg_wdata = '0;
  logic              dbg_gnt, dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  // Memory environment (synchronous, 1-cycle read latency) and its model copy.
  logic [DATA_W-1:0] tb_mem [64];
  logic [DATA_W-1:0] model_mem [64];

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state.
  int                denied;
  int                pend_own;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_cpu_hold, exp_dbg_hold;
  logic              exp_stall_prev;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= tb_mem[mem_addr[7:2]];
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check combinational and response outputs, advance the model.
  task automatic do_cycle(input logic c_req, input logic c_we, input logic [31:0] c_addr,
                          input logic [31:0] c_wd, input logic d_req, input logic d_we,
                          input logic [31:0] d_addr, input logic [31:0] d_wd);
    int                win;
    logic              e_we;
    logic [31:0]       e_addr, e_wd;
    @(negedge clk);
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
    dbg_req = d_req; dbg_we = d_we; dbg_addr = d_addr; dbg_wdata = d_wd;
    #1;
    if (d_req && denied >= MAX_WAIT) win = W_DBG;
    else if (c_req)                  win = W_CPU;
    else if (d_req)                  win = W_DBG;
    else                             win = W_NONE;
    e_we = 1'b0; e_addr = '0; e_wd = '0;
    if (win == W_CPU) begin e_we = c_we; e_addr = c_addr; e_wd = c_wd; end
    if (win == W_DBG) begin e_we = d_we; e_addr = d_addr; e_wd = d_wd; end
    check("mem_we", mem_we, e_we);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wd);
    check("cpu_stall", cpu_stall, c_req && win != W_CPU);
    check("dbg_gnt", dbg_gnt, win == W_DBG);
    if (pend_own != W_NONE && exp_q.size() > 0) begin
      if (pend_own == W_CPU) exp_cpu_hold = exp_q.pop_front();
      else                   exp_dbg_hold = exp_q.pop_front();
    end
    check("cpu_rvalid", cpu_rvalid, pend_own == W_CPU);
    check("dbg_rvalid", dbg_rvalid, pend_own == W_DBG);
    check("cpu_rdata", cpu_rdata, exp_cpu_hold);
    check("dbg_rdata", dbg_rdata, exp_dbg_hold);
    pend_own = W_NONE;
    if (win != W_NONE) begin
      if (e_we) model_mem[e_addr[7:2]] = e_wd;
      else begin
        pend_own = win;
        exp_q.push_back(model_mem[e_addr[7:2]]);
      end
    end
    if (d_req && win != W_DBG) denied = (denied < 15) ? denied + 1 : 15;
    else                       denied = 0;
    exp_stall_prev = c_req && (win != W_CPU);
  endtask

  task automatic idle();
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    #1;
    check("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    check("rst_dbg_rvalid", dbg_rvalid, 1'b0);
    check("rst_cpu_rdata", cpu_rdata, '0);
    check("rst_dbg_rdata", dbg_rdata, '0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    @(negedge clk);
    rstn = 1'b1;
    pend_own = W_NONE; exp_q.delete(); denied = 0;
    exp_cpu_hold = '0; exp_dbg_hold = '0; exp_stall_prev = 1'b0;
  endtask

  logic              r_creq, r_cwe, r_dreq, r_dwe;
  logic [31:0]       r_caddr, r_cwd, r_daddr, r_dwd;

  initial begin
    for (int i = 0; i < 64; i++) begin
      tb_mem[i]    = 32'hA500_0000 + 32'(i);
      model_mem[i] = 32'hA500_0000 + 32'(i);
    end
    tb_mem[4] = 32'hDEADBEEF; model_mem[4] = 32'hDEADBEEF;
    denied = 0; pend_own = W_NONE; exp_cpu_hold = '0; exp_dbg_hold = '0;
    exp_stall_prev = 1'b0;
    do_reset();

    // CPU-only load
    do_cycle(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();
    check("t1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);

    // Debug write then read back
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678);
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    idle();
    check("t2_dbg_rdata", dbg_rdata, 32'h12345678);

    // Continuous contention: debug forced every fifth cycle
    for (int i = 0; i < 10; i++) begin
      do_cycle(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, 32'h84, 32'h0);
      check("t3_period", dbg_gnt, (i % 5) == 4);
    end
    idle();

    // CPU read of 0x40 immediately followed by forced debug read of 0x44
    for (int i = 0; i < 5; i++)
      do_cycle(1'b1, 1'b0, (i < 3) ? 32'h80 : (i == 3) ? 32'h40 : 32'h48, 32'h0,
               1'b1, 1'b0, 32'h44, 32'h0);
    check("t4_cpu_rvalid", cpu_rvalid, 1'b1);
    check("t4_cpu_rdata", cpu_rdata, 32'hA500_0010);
    idle();
    check("t4_dbg_rdata", dbg_rdata, 32'hA500_0011);
    check("t4_cpu_hold", cpu_rdata, 32'hA500_0010);

    // Denial streak broken by a dropped debug request
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'hC, 32'h0);
    do_cycle(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'hC, 32'h0);
    for (int j = 0; j < 5; j++) begin
      do_cycle(1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'hC, 32'h0);
      check("t5_force", dbg_gnt, j == 4);
    end
    idle();

    // Reset while a CPU read response is pending
    do_cycle(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    do_reset();
    idle();
    idle();

    // Random traffic; a stalled CPU holds its request and operands
    r_creq = 1'b0; r_cwe = 1'b0; r_caddr = '0; r_cwd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!exp_stall_prev) begin
        r_creq  = ($urandom_range(0, 9) < 6);
        r_cwe   = ($urandom_range(0, 3) == 0);
        r_caddr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        r_cwd   = $urandom;
      end
      r_dreq  = ($urandom_range(0, 9) < 6);
      r_dwe   = ($urandom_range(0, 3) == 0);
      r_daddr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      r_dwd   = $urandom;
      do_cycle(r_creq, r_cwe, r_caddr, r_cwd, r_dreq, r_dwe, r_daddr, r_dwd);
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
